mem_req_arbiter: RTL and testbench

//  Upstream neighbour of the direct-mapped cache controller: arbitrates instruction-fetch reads,
//  LSU reads and LSU writes onto the controller's single read port and single write port.
//  - Guarantees a read and a write issued in the same cycle never target the same cache line.
//  - Tracks in-flight reads and routes each read response back to its requester.
//  - Honours the controller's miss-repair stall.

---
 rtl/mem_req_arbiter.sv | 105 ++++++++++
 tb/tb_mem_req_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin read arbiter plus line-conflict-aware write path in front of the cache controller.
// Issue latency 1 cycle, read response READ_LAT cycles after issue; c_stall freezes everything and drops all readies.
module mem_req_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LINE_OFF_BITS = 7,
  parameter int READ_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_rd_valid,
  output logic              ls_rd_ready,
  input  logic [ADDR_W-1:0] ls_rd_addr,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  input  logic              ls_wr_valid,
  output logic              ls_wr_ready,
  input  logic [ADDR_W-1:0] ls_wr_addr,
  input  logic [DATA_W-1:0] ls_wr_data,
  output logic              c_raddr_valid,
  output logic [ADDR_W-1:0] c_raddr,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              c_waddr_valid,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_stall
);

  logic                run;
  logic                prio_if;
  logic                c_rid;
  logic [READ_LAT-1:0] pipe_vld;
  logic [READ_LAT-1:0] pipe_id;
  logic                gnt_if;
  logic                gnt_ls;
  logic                gnt_rd;
  logic                conflict;
  logic                wr_acc;
  logic                out_vld;
  logic [ADDR_W-1:0]   rd_addr;

  always_comb begin
    gnt_if   = run & ~c_stall & if_req_valid & (~ls_rd_valid | prio_if);
    gnt_ls   = run & ~c_stall & ls_rd_valid & ~gnt_if;
    gnt_rd   = gnt_if | gnt_ls;
    rd_addr  = gnt_if ? if_req_addr : ls_rd_addr;
    // The read always wins a same-line collision; the write simply retries.
    conflict = ls_wr_valid & gnt_rd &
               (rd_addr[ADDR_W-1:LINE_OFF_BITS] == ls_wr_addr[ADDR_W-1:LINE_OFF_BITS]);
    wr_acc   = ls_wr_valid & ls_wr_ready;
  end

  assign if_req_ready = gnt_if;
  assign ls_rd_ready  = gnt_ls;
  assign ls_wr_ready  = run & ~c_stall & ~conflict;

  // A response held at the pipe exit during a stall is delivered once, when the stall lifts.
  assign out_vld      = pipe_vld[READ_LAT-1] & ~c_stall;
  assign if_rsp_valid = out_vld & ~pipe_id[READ_LAT-1];
  assign ls_rsp_valid = out_vld & pipe_id[READ_LAT-1];
  assign if_rsp_data  = if_rsp_valid ? c_rdata : '0;
  assign ls_rsp_data  = ls_rsp_valid ? c_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run           <= 1'b0;
      prio_if       <= 1'b1;
      c_raddr_valid <= 1'b0;
      c_raddr       <= '0;
      c_rid         <= 1'b0;
      c_waddr_valid <= 1'b0;
      c_waddr       <= '0;
      c_wdata       <= '0;
      pipe_vld      <= '0;
      pipe_id       <= '0;
    end else begin
      run <= 1'b1;
      if (!c_stall) begin
        c_raddr_valid <= gnt_rd;
        if (gnt_rd) begin
          c_raddr <= rd_addr;
          c_rid   <= gnt_ls;
          prio_if <= gnt_ls;
        end
        c_waddr_valid <= wr_acc;
        if (wr_acc) begin
          c_waddr <= ls_wr_addr;
          c_wdata <= ls_wr_data;
        end
        pipe_vld[0] <= c_raddr_valid;
        pipe_id[0]  <= c_rid;
        for (int i = 1; i < READ_LAT; i++) begin
          pipe_vld[i] <= pipe_vld[i-1];
          pipe_id[i]  <= pipe_id[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios then random traffic, checked against a queue-based model.
module tb_mem_req_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LOB = 7;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_valid = 1'b0, ls_rd_valid = 1'b0, ls_wr_valid = 1'b0, c_stall = 1'b0;
  logic [AW-1:0] if_req_addr = '0, ls_rd_addr = '0, ls_wr_addr = '0;
  logic [DW-1:0] ls_wr_data = '0, c_rdata = '0;
  logic          if_req_ready, ls_rd_ready, ls_wr_ready, if_rsp_valid, ls_rsp_valid;
  logic          c_raddr_valid, c_waddr_valid;
  logic [DW-1:0] if_rsp_data, ls_rsp_data, c_wdata;
  logic [AW-1:0] c_raddr, c_waddr;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_OFF_BITS(LOB), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_rd_valid(ls_rd_valid), .ls_rd_ready(ls_rd_ready), .ls_rd_addr(ls_rd_addr),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ls_wr_valid(ls_wr_valid), .ls_wr_ready(ls_wr_ready), .ls_wr_addr(ls_wr_addr),
    .ls_wr_data(ls_wr_data),
    .c_raddr_valid(c_raddr_valid), .c_raddr(c_raddr), .c_rdata(c_rdata),
    .c_waddr_valid(c_waddr_valid), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .c_stall(c_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int rem;
    bit id;
  } rsp_t;
  rsp_t rq[$];

  bit            prio_if = 1'b1;
  bit            e_rv = 1'b0, e_rid = 1'b0, e_wv = 1'b0;
  logic [AW-1:0] e_raddr = '0, e_waddr = '0;
  logic [DW-1:0] e_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a >> LOB;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit iv, input logic [AW-1:0] ia, input bit lv, input logic [AW-1:0] la,
                      input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit st);
    bit   gi, gl, wr_ok, dlv, dlv_id;
    rsp_t h;
    @(posedge clk);
    #1;
    if_req_valid = iv; if_req_addr = ia;
    ls_rd_valid  = lv; ls_rd_addr  = la;
    ls_wr_valid  = wv; ls_wr_addr  = wa; ls_wr_data = wd;
    c_stall      = st; c_rdata     = $urandom;
    cyc++;
    #1;
    gi    = !st && iv && (!lv || prio_if);
    gl    = !st && lv && !gi;
    wr_ok = !st && !(wv && gi && line_of(ia) == line_of(wa)) && !(wv && gl && line_of(la) == line_of(wa));
    chk("if_req_ready", 64'(if_req_ready), 64'(gi));
    chk("ls_rd_ready", 64'(ls_rd_ready), 64'(gl));
    chk("ls_wr_ready", 64'(ls_wr_ready), 64'(wr_ok));
    chk("c_raddr_valid", 64'(c_raddr_valid), 64'(e_rv));
    if (e_rv) chk("c_raddr", 64'(c_raddr), 64'(e_raddr));
    chk("c_waddr_valid", 64'(c_waddr_valid), 64'(e_wv));
    if (e_wv) begin
      chk("c_waddr", 64'(c_waddr), 64'(e_waddr));
      chk("c_wdata", 64'(c_wdata), 64'(e_wdata));
    end
    dlv = 1'b0; dlv_id = 1'b0;
    if (!st) begin
      foreach (rq[i]) rq[i].rem--;
      if (rq.size() > 0 && rq[0].rem == 0) begin
        h = rq.pop_front();
        dlv = 1'b1; dlv_id = h.id;
      end
    end
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'(dlv && !dlv_id));
    chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(dlv && dlv_id));
    if (dlv && !dlv_id) chk("if_rsp_data", 64'(if_rsp_data), 64'(c_rdata));
    if (dlv && dlv_id) chk("ls_rsp_data", 64'(ls_rsp_data), 64'(c_rdata));
    if (e_rv && !st) rq.push_back('{RL, e_rid});
    if (!st) begin
      e_rv = gi || gl;
      if (gi) begin e_raddr = ia; e_rid = 1'b0; prio_if = 1'b0; end
      if (gl) begin e_raddr = la; e_rid = 1'b1; prio_if = 1'b1; end
      e_wv = wv && wr_ok;
      if (e_wv) begin e_waddr = wa; e_wdata = wd; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, '0, 0, '0, '0, 0);
  endtask

  // Assert reset mid-cycle with requests pending; everything must drop at once.
  task automatic do_reset();
    rst = 1'b0;
    if_req_valid = 1'b1; ls_rd_valid = 1'b1; ls_wr_valid = 1'b1; c_stall = 1'b0;
    c_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_if_req_ready", 64'(if_req_ready), 64'd0);
    chk("rst_ls_rd_ready", 64'(ls_rd_ready), 64'd0);
    chk("rst_ls_wr_ready", 64'(ls_wr_ready), 64'd0);
    chk("rst_c_raddr_valid", 64'(c_raddr_valid), 64'd0);
    chk("rst_c_raddr", 64'(c_raddr), 64'd0);
    chk("rst_c_waddr_valid", 64'(c_waddr_valid), 64'd0);
    chk("rst_c_waddr", 64'(c_waddr), 64'd0);
    chk("rst_c_wdata", 64'(c_wdata), 64'd0);
    chk("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    chk("rst_ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
    chk("rst_if_rsp_data", 64'(if_rsp_data), 64'd0);
    chk("rst_ls_rsp_data", 64'(ls_rsp_data), 64'd0);
    rq.delete();
    prio_if = 1'b1; e_rv = 1'b0; e_wv = 1'b0; e_rid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rel_if_req_ready", 64'(if_req_ready), 64'd0);
    chk("rel_ls_wr_ready", 64'(ls_wr_ready), 64'd0);
  endtask

  initial begin
    bit            iv, lv, wv, st;
    logic [AW-1:0] ia, la, wa;
    #2;
    do_reset();

    // Single fetch: issue next cycle, response READ_LAT cycles after issue.
    step(1, 32'h100, 0, '0, 0, '0, '0, 0);
    idle(2);
    chk("t1_no_rsp_early", 64'(if_rsp_valid), 64'd0);
    idle(1);
    chk("t1_if_rsp_latency", 64'(if_rsp_valid), 64'd1);
    idle(2);

    // Both read requesters continuously valid: grants alternate.
    for (int k = 0; k < 6; k++) step(1, 32'h400 + 32'(k * 4), 1, 32'h800 + 32'(k * 4), 0, '0, '0, 0);
    idle(RL + 2);

    // Same-line read/write: read goes, write retries.
    step(0, '0, 1, 32'h1000, 1, 32'h1040, 32'hA5A5_0001, 0);
    chk("t3_wr_blocked", 64'(ls_wr_ready), 64'd0);
    step(0, '0, 0, '0, 1, 32'h1040, 32'hA5A5_0001, 0);
    chk("t3_read_issued", 64'(c_raddr_valid), 64'd1);
    idle(1);
    chk("t3_write_issued", 64'(c_waddr_valid), 64'd1);
    idle(RL + 1);

    // Different lines: read and write issue together.
    step(0, '0, 1, 32'h1000, 1, 32'h1080, 32'h5A5A_0002, 0);
    idle(1);
    chk("t4_both_issue", 64'({c_raddr_valid, c_waddr_valid}), 64'd3);
    idle(RL + 1);

    // Stall for 3 cycles with reads in flight.
    step(1, 32'h200, 0, '0, 0, '0, '0, 0);
    step(0, '0, 1, 32'h300, 0, '0, '0, 0);
    for (int k = 0; k < 3; k++) step(1, 32'h600, 1, 32'h700, 1, 32'h900, 32'h1, 1);
    idle(RL + 3);

    // Reset with two reads in flight: neither may be answered.
    step(1, 32'h400, 0, '0, 0, '0, '0, 0);
    step(0, '0, 1, 32'h500, 0, '0, '0, 0);
    do_reset();
    idle(RL + 3);

    // Random traffic over a handful of lines to provoke conflicts.
    for (int k = 0; k < 400; k++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      ia = 32'h2000 + (32'($urandom_range(0, 3)) << LOB) + 32'($urandom_range(0, 127));
      la = 32'h2000 + (32'($urandom_range(0, 3)) << LOB) + 32'($urandom_range(0, 127));
      wa = 32'h2000 + (32'($urandom_range(0, 3)) << LOB) + 32'($urandom_range(0, 127));
      step(iv, ia, lv, la, wv, wa, $urandom, st);
    end
    idle(RL + 4);
    chk("drain_all_responses", 64'(rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
